uart_rx_os4: RTL and testbench

//   8N1 UART receiver driven by the 4x-oversampling baudtick from the baud generator.

---
 rtl/uart_rx_os4.sv | 142 ++++++++++++++
 tb/tb_uart_rx_os4.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os4.sv
// 8N1 UART receiver, 4x oversampled, with a valid/ready holding register.
// Flags framing errors and overruns as single-cycle pulses.
module uart_rx_os4 #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 baudtick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_e                 state_q, state_d;
  logic [1:0]             tcnt_q, tcnt_d;
  logic [BW-1:0]          bidx_q, bidx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;

  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ovr_q;

  logic                   stop_tick;
  logic                   good;
  logic                   bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
    end
  end

  // Start sample lands 2 ticks after T0, every later sample 4 ticks apart.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    if (baudtick) begin
      tcnt_d = tcnt_q + 2'd1;
      unique case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            tcnt_d  = '0;
          end
        end
        S_START: begin
          if (tcnt_q == 2'd1) begin
            tcnt_d  = '0;
            bidx_d  = '0;
            state_d = rxs ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tcnt_q == 2'd3) begin
            shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
            bidx_d  = bidx_q + 1'b1;
            if (bidx_q == LAST) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (tcnt_q == 2'd3) state_d = rxs ? S_IDLE : S_BRK;
        end
        S_BRK: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    stop_tick = baudtick && (state_q == S_STOP) && (tcnt_q == 2'd3);
    good      = stop_tick && rxs;
    bad       = stop_tick && !rxs;
  end

  // A load in the handshake cycle wins over the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= bad;
      ovr_q  <= good && valid_q && !rx_ready;
      if (good && (!valid_q || rx_ready)) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os4.sv
// Directed bench for uart_rx_os4: baudtick every 10 clk, one bit = 40 clk.
// Counts frame_err/overrun pulses and delivered bytes on the negedge.
module tb_uart_rx_os4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       baudtick = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] got[$];
  int n0;

  uart_rx_os4 #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .baudtick (baudtick),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (9) @(posedge clk);
      #1 baudtick = 1'b1;
      @(posedge clk);
      #1 baudtick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) got.push_back(rx_data);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_clk(40);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(40);
    end
    rxd = stop;
    wait_clk(40);
  endtask

  task automatic accept(input string tag, input logic [7:0] exp);
    n0 = got.size();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    chk({tag, "_clr"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_n"}, got.size(), n0 + 1);
    if (got.size() > 0) chk({tag, "_byte"}, {24'd0, got[$]}, {24'd0, exp});
  endtask

  initial begin
    wait_clk(5);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    wait_clk(23);

    // 1: basic byte, held until accepted
    send(8'hA5, 1'b1);
    chk("t1_valid", {31'd0, rx_valid}, 32'd1);
    chk("t1_data", {24'd0, rx_data}, 32'hA5);
    wait_clk(30);
    chk("t1_hold", {31'd0, rx_valid}, 32'd1);
    chk("t1_hold_d", {24'd0, rx_data}, 32'hA5);
    accept("t1", 8'hA5);
    wait_clk(20);

    // 2: false start
    rxd = 1'b0;
    wait_clk(10);
    rxd = 1'b1;
    wait_clk(40);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_valid", {31'd0, rx_valid}, 32'd0);
    chk("t2_fe", fe_cnt, 32'd0);
    wait_clk(20);

    // 3: bad stop then break, then good frame
    send(8'h3C, 1'b0);
    wait_clk(200);
    chk("t3_fe", fe_cnt, 32'd1);
    chk("t3_valid", {31'd0, rx_valid}, 32'd0);
    chk("t3_brk", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    wait_clk(40);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_fe2", fe_cnt, 32'd1);
    send(8'h3C, 1'b1);
    chk("t3_valid2", {31'd0, rx_valid}, 32'd1);
    chk("t3_data", {24'd0, rx_data}, 32'h3C);
    accept("t3", 8'h3C);
    wait_clk(20);

    // 4: overrun keeps the old byte
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    wait_clk(10);
    chk("t4_ovr", ov_cnt, 32'd1);
    chk("t4_valid", {31'd0, rx_valid}, 32'd1);
    chk("t4_data", {24'd0, rx_data}, 32'h11);
    chk("t4_fe", fe_cnt, 32'd1);
    accept("t4", 8'h11);
    wait_clk(20);

    // 5: reset during data bit 3 of 0x77
    rxd = 1'b0;
    wait_clk(40);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b1;
      wait_clk(40);
    end
    rxd = 1'b0;
    wait_clk(20);
    rstn = 1'b0;
    #1;
    chk("t5_data", {24'd0, rx_data}, 32'd0);
    chk("t5_valid", {31'd0, rx_valid}, 32'd0);
    chk("t5_ferr", {31'd0, frame_err}, 32'd0);
    chk("t5_ovr", {31'd0, overrun}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    wait_clk(10);
    rstn = 1'b1;
    wait_clk(40);
    send(8'h5A, 1'b1);
    chk("t5_valid2", {31'd0, rx_valid}, 32'd1);
    chk("t5_data2", {24'd0, rx_data}, 32'h5A);
    chk("t5_fe", fe_cnt, 32'd1);
    chk("t5_ov", ov_cnt, 32'd1);
    accept("t5", 8'h5A);
    wait_clk(20);

    // 6: ready tied high, back-to-back 0x00 / 0xFF
    n0 = got.size();
    rx_ready = 1'b1;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    wait_clk(20);
    rx_ready = 1'b0;
    chk("t6_n", got.size(), n0 + 2);
    if (got.size() >= n0 + 2) begin
      chk("t6_b0", {24'd0, got[n0]}, 32'h00);
      chk("t6_b1", {24'd0, got[n0+1]}, 32'hFF);
    end
    chk("t6_valid", {31'd0, rx_valid}, 32'd0);
    chk("t6_fe", fe_cnt, 32'd1);
    chk("t6_ov", ov_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
